// File: rtl/weight_loader.sv
// Double-buffered weight tile loader: SRAM rows are captured into a shadow bank and committed to the active tile on a prefetch pulse.
// Optional sticky drop flag overflow_err_out is enabled by defining WEIGHT_LOADER_OVERFLOW_ERR_EN.
module weight_loader #(
  parameter int MAC_ROW    = 16,
  parameter int MAC_COL    = 16,
  parameter int W_BITWIDTH = 8,
  parameter int W_ADDR_BIT = 11
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  w_read_en_in,
  input  logic [W_ADDR_BIT-1:0]                 w_addr_in,
  input  logic                                  w_prefetch_in,
  output logic                                  sram_en_out,
  output logic [W_ADDR_BIT-1:0]                 sram_addr_out,
  input  logic [MAC_COL*W_BITWIDTH-1:0]         sram_rdata_in,
  output logic [MAC_ROW*MAC_COL*W_BITWIDTH-1:0] weight_out,
  output logic                                  weight_valid_out,
  output logic                                  shadow_full_out,
  output logic [$clog2(MAC_ROW+1)-1:0]          row_count_out
`ifdef WEIGHT_LOADER_OVERFLOW_ERR_EN
  ,
  output logic                                  overflow_err_out
`endif
);

  localparam int RW = MAC_COL * W_BITWIDTH;
  localparam int CW = $clog2(MAC_ROW + 1);
  localparam int IW = (MAC_ROW > 1) ? $clog2(MAC_ROW) : 1;

  logic                  sram_en_q;
  logic [W_ADDR_BIT-1:0] sram_addr_q;
  logic                  rd_pend_q;
  logic                  pending_q;
  logic [CW-1:0]         row_count_q;
  logic                  valid_q;
  logic [RW-1:0]         shadow_q [MAC_ROW];
  logic [MAC_ROW*RW-1:0] shadow_flat;
  logic [MAC_ROW*RW-1:0] weight_q;

  logic          full;
  logic          commit_now;
  logic          req_accept;
  logic          capture;
  logic [IW-1:0] cap_idx;

  // A commit on this edge empties the shadow bank, so a full bank only blocks
  // new requests and captures when no commit coincides with them.
  assign full       = (row_count_q == CW'(MAC_ROW));
  assign commit_now = full & (w_prefetch_in | pending_q);
  assign req_accept = w_read_en_in & (~full | commit_now);
  assign capture    = rd_pend_q & (~full | commit_now);
  assign cap_idx    = commit_now ? '0 : row_count_q[IW-1:0];

  for (genvar r = 0; r < MAC_ROW; r++) begin : g_flat
    assign shadow_flat[r*RW +: RW] = shadow_q[r];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_en_q   <= 1'b0;
      sram_addr_q <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      sram_en_q <= req_accept;
      if (req_accept) sram_addr_q <= w_addr_in;
      rd_pend_q <= sram_en_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else if (commit_now) begin
      pending_q <= 1'b0;
    end else if (w_prefetch_in && !full) begin
      pending_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < MAC_ROW; r++) shadow_q[r] <= '0;
      row_count_q <= '0;
    end else begin
      if (capture) shadow_q[cap_idx] <= sram_rdata_in;
      if (commit_now) row_count_q <= capture ? CW'(1) : '0;
      else if (capture) row_count_q <= row_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_q <= '0;
      valid_q  <= 1'b0;
    end else if (commit_now) begin
      weight_q <= shadow_flat;
      valid_q  <= 1'b1;
    end
  end

`ifdef WEIGHT_LOADER_OVERFLOW_ERR_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else if ((w_read_en_in | rd_pend_q) & full & ~commit_now) ovf_q <= 1'b1;
  end
  assign overflow_err_out = ovf_q;
`endif

  assign sram_en_out      = sram_en_q;
  assign sram_addr_out    = sram_addr_q;
  assign weight_out       = weight_q;
  assign weight_valid_out = valid_q;
  assign shadow_full_out  = full;
  assign row_count_out    = row_count_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: cycle table for fill/overflow/commit, hand sequences for deferred commit, coincident capture and reset.
module tb_weight_loader;
  localparam int ROWS = 16;
  localparam int RW   = 128;
  localparam int AW   = 11;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 rd_en = 1'b0;
  logic [AW-1:0]        addr = '0;
  logic                 pf = 1'b0;
  logic                 sram_en;
  logic [AW-1:0]        sram_addr;
  logic [RW-1:0]        sram_rdata = '0;
  logic [ROWS*RW-1:0]   weight;
  logic                 valid;
  logic                 full;
  logic [4:0]           cnt;
  logic                 ovf;

  int checks = 0;
  int errors = 0;

  weight_loader dut (
    .clk(clk), .rst(rst), .w_read_en_in(rd_en), .w_addr_in(addr), .w_prefetch_in(pf),
    .sram_en_out(sram_en), .sram_addr_out(sram_addr), .sram_rdata_in(sram_rdata),
    .weight_out(weight), .weight_valid_out(valid), .shadow_full_out(full),
    .row_count_out(cnt)
`ifdef WEIGHT_LOADER_OVERFLOW_ERR_EN
    , .overflow_err_out(ovf)
`endif
  );

`ifndef WEIGHT_LOADER_OVERFLOW_ERR_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] rep(input logic [7:0] b);
    logic [RW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = b;
    return v;
  endfunction

  // SRAM row k holds byte k[7:0] in every lane; data appears one cycle after the enable
  always @(posedge clk) if (sram_en) sram_rdata <= rep(sram_addr[7:0]);

  typedef struct {
    logic rd; logic [AW-1:0] a; logic p;
    logic en; logic [AW-1:0] ea; logic [4:0] c; logic f; logic v;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic rd, input int a, input logic p, input logic en,
                              input int ea, input int c, input logic f, input logic v);
    vec_t t;
    t = '{rd, AW'(a), p, en, AW'(ea), 5'(c), f, v};
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Active tile is expected to hold row r = base+r in every lane
  task automatic chk_tile(input string name, input logic [7:0] base);
    int bad;
    bad = -1;
    for (int r = ROWS - 1; r >= 0; r--)
      if (weight[r*RW +: RW] !== rep(8'(base + r))) bad = r;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s row%0d: got %0h expected %0h", name, bad,
               weight[bad*RW +: RW], rep(8'(base + bad)));
    end
  endtask

  task automatic step(input logic r, input int a, input logic p);
    rd_en = r; addr = AW'(a); pf = p;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #3 rst = 1'b1;
    #1;
    chk("rst_en", sram_en, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_full", full, 0);
    chk("rst_valid", valid, 0);
    chk("rst_weight", (weight == '0), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill 0..15, drain, extra reads while full, then commit
    for (int k = 0; k < 16; k++) add(1, k, 0, 1, k, (k == 0) ? 0 : k - 1, 0, 0);
    add(0, 0, 0, 0, 0, 15, 0, 0);
    add(0, 0, 0, 0, 0, 16, 1, 0);
    for (int k = 0; k < 3; k++) add(1, 16 + k, 0, 0, 0, 16, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rd, int'(tbl[i].a), tbl[i].p);
      chk($sformatf("t%0d_en", i), sram_en, tbl[i].en);
      if (tbl[i].en) chk($sformatf("t%0d_addr", i), sram_addr, tbl[i].ea);
      chk($sformatf("t%0d_cnt", i), cnt, tbl[i].c);
      chk($sformatf("t%0d_full", i), full, tbl[i].f);
      chk($sformatf("t%0d_valid", i), valid, tbl[i].v);
    end
    chk("tileA_row5", weight[5*RW +: RW], rep(8'h05));
    chk_tile("tileA", 8'h00);
`ifdef WEIGHT_LOADER_OVERFLOW_ERR_EN
    chk("ovf_after_drop", ovf, 1);
`endif

    // Early prefetch after 10 rows, second prefetch while waiting
    for (int k = 0; k < 10; k++) step(1, 'h40 + k, 0);
    step(0, 0, 0); step(0, 0, 0);
    chk("b_cnt10", cnt, 10);
    step(0, 0, 1);
    chk("b_wait_tile", (weight[RW-1:0] == rep(8'h00)), 1);
    chk("b_wait_cnt", cnt, 10);
    for (int k = 0; k < 6; k++) step(1, 'h4a + k, k == 2);
    step(0, 0, 0);
    chk("b_cnt15", cnt, 15);
    step(0, 0, 0);
    chk("b_full", full, 1);
    chk_tile("b_still_A", 8'h00);
    step(0, 0, 0);
    chk_tile("tileB", 8'h40);
    chk("b_cnt0", cnt, 0);
    chk("b_full0", full, 0);

    // Fill with one extra read in flight; no leftover pending, extra read dropped
    for (int k = 0; k < 17; k++) step(1, (k < 16) ? 'h60 + k : 'h20, 0);
    step(0, 0, 0);
    chk("c_full", full, 1);
    step(0, 0, 0);
    chk_tile("c_no_commit", 8'h40);
    chk("c_cnt16", cnt, 16);
    step(0, 0, 1);
    chk_tile("tileC", 8'h60);
    chk("c_cnt0", cnt, 0);

    // Pending commit coincides with capture of address 0x20
    step(0, 0, 1);
    for (int k = 0; k < 17; k++) step(1, (k < 16) ? 'h80 + k : 'h20, 0);
    step(0, 0, 0);
    chk("d_full", full, 1);
    step(0, 0, 0);
    chk_tile("tileD", 8'h80);
    chk("d_cnt1", cnt, 1);
    chk("d_full0", full, 0);
    for (int k = 0; k < 15; k++) step(1, 'h90 + k, 0);
    step(0, 0, 0); step(0, 0, 0);
    chk("e_cnt16", cnt, 16);
    step(0, 0, 1);
    chk("e_row0", weight[RW-1:0], rep(8'h20));
    chk("e_row1", weight[RW +: RW], rep(8'h90));
    chk("e_row15", weight[15*RW +: RW], rep(8'h9e));
`ifdef WEIGHT_LOADER_OVERFLOW_ERR_EN
    chk("ovf_sticky", ovf, 1);
`endif

    // Reset mid-tile with two reads in flight
    for (int k = 0; k < 9; k++) step(1, 'h10 + k, 0);
    rd_en = 1'b0; addr = '0; pf = 1'b0;
    chk("f_cnt7", cnt, 7);
    #2 rst = 1'b1;
    #1;
    chk("f_rst_en", sram_en, 0);
    chk("f_rst_addr", sram_addr, 0);
    chk("f_rst_cnt", cnt, 0);
    chk("f_rst_valid", valid, 0);
    chk("f_rst_weight", (weight == '0), 1);
    chk("f_rst_ovf", ovf, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("f_no_capture", cnt, 0);
    chk("f_valid0", valid, 0);
    for (int k = 0; k < 16; k++) step(1, 'h33 + k, 0);
    step(0, 0, 0); step(0, 0, 0);
    chk("f_cnt16", cnt, 16);
    step(0, 0, 1);
    chk_tile("tileF", 8'h33);
    chk("f_ovf_clear", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 The block SHALL be parameterized as follows (name, default, meaning): MAC_ROW, 16, rows per weight tile; MAC_COL, 16, columns per row; W_BITWIDTH, 8, bits per weight; W_ADDR_BIT, 11, weight SRAM address width.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port w_read_en_in  input  1  read request from the weight controller.
REQ-005 Port w_addr_in  input  W_ADDR_BIT  weight SRAM row address, valid with w_read_en_in.
REQ-006 Port w_prefetch_in  input  1  single-cycle pulse: commit the shadow tile to the MAC array.
REQ-007 Port sram_en_out  output  1  weight SRAM read enable.
REQ-008 Port sram_addr_out  output  W_ADDR_BIT  weight SRAM read address.
REQ-009 Port sram_rdata_in  input  MAC_COL*W_BITWIDTH  SRAM read data, valid one cycle after sram_en_out.
REQ-010 Port weight_out  output  MAC_ROW*MAC_COL*W_BITWIDTH  active weight tile; row r occupies bits [(r+1)*MAC_COL*W_BITWIDTH-1 : r*MAC_COL*W_BITWIDTH].
REQ-011 Port weight_valid_out  output  1  active tile holds a committed tile.
REQ-012 Port shadow_full_out  output  1  shadow bank holds MAC_ROW captured rows.
REQ-013 Port row_count_out  output  $clog2(MAC_ROW+1)  number of rows captured in the shadow bank.

Function
REQ-014 sram_en_out/sram_addr_out SHALL be w_read_en_in/w_addr_in registered once: request at edge t drives SRAM at t+1.
REQ-015 Data SHALL be written to shadow row row_count_out at edge t+2, and row_count_out SHALL then increment, for a total request-to-capture latency of 2 cycles.
REQ-016 Back-to-back requests SHALL be accepted every cycle with no bubbles.
REQ-017 When row_count_out reaches MAC_ROW, shadow_full_out SHALL be 1.
REQ-018 A request arriving while shadow_full_out=1 and no commit is pending in the same cycle SHALL be dropped: no sram_en_out is issued and no state changes.
REQ-019 Requests in flight at the moment shadow_full_out becomes 1 SHALL be dropped at capture.
REQ-020 On w_prefetch_in with shadow_full_out=1, the next edge SHALL copy shadow to active, set weight_valid_out=1, clear shadow_full_out, and reset row_count_out to 0.
REQ-021 On w_prefetch_in with shadow_full_out=0, a pending flag SHALL be set, and the commit of REQ-020 SHALL occur on the edge after the tile becomes full.
REQ-022 A second w_prefetch_in while the pending flag is set SHALL be ignored.
REQ-023 If a commit and a read capture fall on the same edge, the capture SHALL go to row 0 of the freshly emptied shadow bank, and row_count_out SHALL become 1.
REQ-024 weight_out SHALL change only at commit edges and SHALL otherwise hold.

Reset
REQ-025 While rst=1, the following SHALL be 0 immediately, independent of clk: sram_en_out, sram_addr_out, weight_out, weight_valid_out, shadow_full_out, row_count_out, the pending flag, the in-flight pipeline and the shadow bank.
REQ-026 Assertion of rst mid-tile SHALL discard partial rows and in-flight reads; operation SHALL restart at row 0 on the first edge after deassertion.

Configuration
REQ-027 With macro WEIGHT_LOADER_OVERFLOW_ERR_EN defined, the block SHALL add output port overflow_err_out (1 bit), set sticky on any request dropped by REQ-018 or REQ-019 and cleared only by rst.
REQ-028 Without WEIGHT_LOADER_OVERFLOW_ERR_EN, the port SHALL be absent and drops SHALL be silent.

Verification
REQ-029 Reset release followed by 16 consecutive reads at addresses 0..15 (SRAM row k = {16{k[7:0]}}) -> sram_en_out high in cycles 1..16; row_count_out=16 and shadow_full_out=1 two cycles after the last request.
REQ-030 Full tile, then prefetch pulse -> next edge: weight_valid_out=1, row 5 of weight_out = 0x05 repeated 16 times, row_count_out=0.
REQ-031 Prefetch pulse after 10 rows, then 6 more reads -> weight_out unchanged until 1 edge after the 16th capture, then updates; second prefetch pulse during the wait has no effect.
REQ-032 Full shadow bank, then 3 extra reads with no prefetch -> no sram_en_out, row_count_out stays 16; with the macro, overflow_err_out=1 and it stays 1 until rst.
REQ-033 Prefetch commit edge coincides with a read capture at address 0x20 -> active tile is the old shadow, shadow row 0 = data at 0x20, row_count_out=1.
REQ-034 rst pulse after 7 captured rows with 2 reads in flight -> all outputs 0 asynchronously; no capture after release; next read lands in row 0.
